// File: rtl/basic_io_unit.sv
// basic_io_unit: character I/O for the basic computer.
// An input FIFO decouples the keyboard from INPR/FGI, and an output FIFO
// decouples OUTR/FGO from the printer. All outputs derive from registered state.
module basic_io_unit #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dev_in_data,
    input  logic       dev_in_valid,
    output logic       dev_in_ready,
    output logic [7:0] dev_out_data,
    output logic       dev_out_valid,
    input  logic       dev_out_ready,
    output logic [7:0] INPR,
    output logic       FGI,
    input  logic       clr_FGI,
    input  logic [7:0] OUTR_in,
    input  logic       load_OUTR,
    input  logic       clr_FGO,
    output logic [7:0] OUTR,
    output logic       FGO,
    output logic       out_overrun
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam logic [IAW:0] IN_FULL_CNT  = (IAW+1)'(IN_DEPTH);
    localparam logic [OAW:0] OUT_FULL_CNT = (OAW+1)'(OUT_DEPTH);

    // Input side state
    logic [7:0]   in_mem_q [IN_DEPTH];
    logic [IAW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
    logic [IAW:0]   in_cnt_q, in_cnt_d;
    logic [7:0]   inpr_q, inpr_d;
    logic         fgi_q, fgi_d;
    logic         in_full, in_empty, in_push, in_pop;

    // Output side state
    logic [7:0]   out_mem_q [OUT_DEPTH];
    logic [OAW-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
    logic [OAW:0]   out_cnt_q, out_cnt_d;
    logic [7:0]   outr_q, outr_d;
    logic         fgo_q, fgo_d;
    logic         ovr_q, ovr_d;
    logic         out_full, out_empty, out_push, out_pop;

    assign in_full   = (in_cnt_q == IN_FULL_CNT);
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == OUT_FULL_CNT);
    assign out_empty = (out_cnt_q == '0);

    // Push is gated by the registered full flag only, so a same-cycle pop
    // never opens a slot early and ready has no input dependence.
    assign in_push  = dev_in_valid & ~in_full;
    // Refill INPR whenever it has been consumed (FGI low) and bytes wait.
    assign in_pop   = ~fgi_q & ~in_empty;
    // OUTR moves into the FIFO while FGO is low and there is room.
    assign out_push = ~fgo_q & ~out_full;
    assign out_pop  = ~out_empty & dev_out_ready;

    assign dev_in_ready  = ~in_full;
    assign dev_out_valid = ~out_empty;
    assign dev_out_data  = out_empty ? 8'h00 : out_mem_q[out_rptr_q];
    assign INPR          = inpr_q;
    assign FGI           = fgi_q;
    assign OUTR          = outr_q;
    assign FGO           = fgo_q;
    assign out_overrun   = ovr_q;

    // Input FIFO pointers/occupancy and the INPR/FGI handshake
    always_comb begin
        in_wptr_d = in_wptr_q;
        in_rptr_d = in_rptr_q;
        in_cnt_d  = in_cnt_q;
        inpr_d    = inpr_q;
        fgi_d     = fgi_q;
        if (in_push) in_wptr_d = in_wptr_q + IAW'(1);
        if (in_pop) begin
            in_rptr_d = in_rptr_q + IAW'(1);
            inpr_d    = in_mem_q[in_rptr_q];
            fgi_d     = 1'b1;
        end else if (clr_FGI && fgi_q) begin
            fgi_d = 1'b0;
        end
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + (IAW+1)'(1);
            2'b01:   in_cnt_d = in_cnt_q - (IAW+1)'(1);
            default: in_cnt_d = in_cnt_q;
        endcase
    end

    // Output FIFO pointers/occupancy, OUTR/FGO handshake and overrun flag
    always_comb begin
        out_wptr_d = out_wptr_q;
        out_rptr_d = out_rptr_q;
        out_cnt_d  = out_cnt_q;
        outr_d     = outr_q;
        fgo_d      = fgo_q;
        ovr_d      = ovr_q;
        if (out_push) out_wptr_d = out_wptr_q + OAW'(1);
        if (out_pop)  out_rptr_d = out_rptr_q + OAW'(1);
        // clr_FGO has priority over the transfer setting FGO.
        if (clr_FGO)       fgo_d = 1'b0;
        else if (out_push) fgo_d = 1'b1;
        if (load_OUTR) begin
            outr_d = OUTR_in;
            if (!fgo_q && !out_push) ovr_d = 1'b1;
        end
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + (OAW+1)'(1);
            2'b01:   out_cnt_d = out_cnt_q - (OAW+1)'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Control state with asynchronous reset; reset drops any buffered bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wptr_q  <= '0;
            in_rptr_q  <= '0;
            in_cnt_q   <= '0;
            inpr_q     <= 8'h00;
            fgi_q      <= 1'b0;
            out_wptr_q <= '0;
            out_rptr_q <= '0;
            out_cnt_q  <= '0;
            outr_q     <= 8'h00;
            fgo_q      <= 1'b1;
            ovr_q      <= 1'b0;
        end else begin
            in_wptr_q  <= in_wptr_d;
            in_rptr_q  <= in_rptr_d;
            in_cnt_q   <= in_cnt_d;
            inpr_q     <= inpr_d;
            fgi_q      <= fgi_d;
            out_wptr_q <= out_wptr_d;
            out_rptr_q <= out_rptr_d;
            out_cnt_q  <= out_cnt_d;
            outr_q     <= outr_d;
            fgo_q      <= fgo_d;
            ovr_q      <= ovr_d;
        end
    end

    // FIFO storage; contents are don't-care while the matching count is zero
    always_ff @(posedge clk) begin
        if (in_push)  in_mem_q[in_wptr_q]   <= dev_in_data;
        if (out_push) out_mem_q[out_wptr_q] <= outr_q;
    end
endmodule

// File: tb/tb_basic_io_unit.sv
// Self-checking bench for basic_io_unit: scenario tasks with inline checks,
// plus scoreboards for bytes delivered to INPR and to the output device.
module tb_basic_io_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dev_in_data = 8'h00;
    logic       dev_in_valid = 1'b0;
    logic       dev_in_ready;
    logic [7:0] dev_out_data;
    logic       dev_out_valid;
    logic       dev_out_ready = 1'b0;
    logic [7:0] INPR;
    logic       FGI;
    logic       clr_FGI = 1'b0;
    logic [7:0] OUTR_in = 8'h00;
    logic       load_OUTR = 1'b0;
    logic       clr_FGO = 1'b0;
    logic [7:0] OUTR;
    logic       FGO;
    logic       out_overrun;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] in_exp_q[$];
    logic [7:0] out_exp_q[$];
    logic [7:0] in_exp_b, out_exp_b;
    logic       fgi_prev = 1'b0;

    always #5 clk = ~clk;

    basic_io_unit #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
        .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
        .INPR(INPR), .FGI(FGI), .clr_FGI(clr_FGI),
        .OUTR_in(OUTR_in), .load_OUTR(load_OUTR), .clr_FGO(clr_FGO),
        .OUTR(OUTR), .FGO(FGO), .out_overrun(out_overrun)
    );

    // INPR scoreboard: every rising FGI must present the next expected byte
    always @(negedge clk) begin
        if (rst_n && FGI && !fgi_prev) begin
            compared++;
            if (in_exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL inpr_unexpected: got %h want none", INPR);
            end else begin
                in_exp_b = in_exp_q.pop_front();
                if (INPR !== in_exp_b) begin
                    mismatched++;
                    $display("FAIL inpr_byte: got %h want %h", INPR, in_exp_b);
                end else $display("INPR byte %h", INPR);
            end
        end
        fgi_prev <= FGI;
    end

    // Output device scoreboard: every handshake must deliver the next expected byte
    always @(negedge clk) begin
        if (rst_n && dev_out_valid && dev_out_ready) begin
            compared++;
            if (out_exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL out_unexpected: got %h want none", dev_out_data);
            end else begin
                out_exp_b = out_exp_q.pop_front();
                if (dev_out_data !== out_exp_b) begin
                    mismatched++;
                    $display("FAIL out_byte: got %h want %h", dev_out_data, out_exp_b);
                end else $display("device byte %h", dev_out_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        in_exp_q.delete();
        out_exp_q.delete();
        rst_n = 1'b1;
        step();
    endtask

    task automatic do_out(input logic [7:0] b);
        clr_FGO = 1'b1; load_OUTR = 1'b1; OUTR_in = b;
        step();
        clr_FGO = 1'b0; load_OUTR = 1'b0;
    endtask

    task automatic wait_fgo(input string name);
        for (int t = 0; t < 10 && FGO !== 1'b1; t++) step();
        chk(name, {7'd0, FGO}, 8'h01);
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 30 && out_exp_q.size() != 0; t++) step();
        step();
        chk(name, 8'(out_exp_q.size()), 8'h00);
    endtask

    task automatic test_reset();
        dev_in_data = 8'h99; dev_in_valid = 1'b1; in_exp_q.push_back(8'h99);
        step();
        dev_in_valid = 1'b0;
        do_out(8'h42);
        step();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_inpr", INPR, 8'h00);
        chk("rst_fgi", {7'd0, FGI}, 8'h00);
        chk("rst_fgo", {7'd0, FGO}, 8'h01);
        chk("rst_outr", OUTR, 8'h00);
        chk("rst_in_ready", {7'd0, dev_in_ready}, 8'h01);
        chk("rst_out_valid", {7'd0, dev_out_valid}, 8'h00);
        chk("rst_out_data", dev_out_data, 8'h00);
        chk("rst_overrun", {7'd0, out_overrun}, 8'h00);
        in_exp_q.delete();
        out_exp_q.delete();
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_input_path();
        dev_in_data = 8'hAB; dev_in_valid = 1'b1; in_exp_q.push_back(8'hAB);
        step();
        dev_in_data = 8'hCD; in_exp_q.push_back(8'hCD);
        step();
        dev_in_valid = 1'b0;
        chk("in_inpr_ab", INPR, 8'hAB);
        chk("in_fgi_set", {7'd0, FGI}, 8'h01);
        clr_FGI = 1'b1; step(); clr_FGI = 1'b0;
        chk("in_fgi_clr", {7'd0, FGI}, 8'h00);
        chk("in_inpr_kept", INPR, 8'hAB);
        step();
        chk("in_inpr_cd", INPR, 8'hCD);
        chk("in_fgi_reset", {7'd0, FGI}, 8'h01);
    endtask

    task automatic test_in_backpressure();
        clr_FGI = 1'b1; step(); clr_FGI = 1'b0;
        chk("bp_fgi_start", {7'd0, FGI}, 8'h00);
        for (int b = 1; b <= 5; b++) begin
            dev_in_valid = 1'b1; dev_in_data = 8'(b); in_exp_q.push_back(8'(b));
            step();
        end
        dev_in_data = 8'h06; in_exp_q.push_back(8'h06);
        step(); step();
        chk("bp_ready_full", {7'd0, dev_in_ready}, 8'h00);
        chk("bp_inpr_01", INPR, 8'h01);
        chk("bp_fgi_held", {7'd0, FGI}, 8'h01);
        clr_FGI = 1'b1; step(); clr_FGI = 1'b0;
        chk("bp_ready_after_clr", {7'd0, dev_in_ready}, 8'h00);
        step();
        chk("bp_ready_free", {7'd0, dev_in_ready}, 8'h01);
        chk("bp_inpr_02", INPR, 8'h02);
        step();
        dev_in_valid = 1'b0;
        chk("bp_ready_06_taken", {7'd0, dev_in_ready}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            clr_FGI = 1'b1; step(); clr_FGI = 1'b0;
            chk("b2b_fgi_low", {7'd0, FGI}, 8'h00);
            step();
            chk("b2b_fgi_high", {7'd0, FGI}, 8'h01);
        end
        clr_FGI = 1'b1; step(); clr_FGI = 1'b0;
        step();
        chk("bp_fgi_empty", {7'd0, FGI}, 8'h00);
        chk("bp_in_sb_empty", 8'(in_exp_q.size()), 8'h00);
    endtask

    task automatic test_output_path();
        dev_out_ready = 1'b1;
        out_exp_q.push_back(8'h5A);
        do_out(8'h5A);
        chk("op_fgo_low", {7'd0, FGO}, 8'h00);
        chk("op_outr", OUTR, 8'h5A);
        chk("op_valid_early", {7'd0, dev_out_valid}, 8'h00);
        step();
        chk("op_fgo_high", {7'd0, FGO}, 8'h01);
        chk("op_valid", {7'd0, dev_out_valid}, 8'h01);
        chk("op_data", dev_out_data, 8'h5A);
        step();
        chk("op_valid_done", {7'd0, dev_out_valid}, 8'h00);
        chk("op_data_zero", dev_out_data, 8'h00);
    endtask

    task automatic test_output_full();
        dev_out_ready = 1'b0;
        for (int b = 8'h10; b <= 8'h14; b++) begin
            wait_fgo("of_wait_fgo");
            if (b != 8'h14) out_exp_q.push_back(8'(b));
            do_out(8'(b));
        end
        step(); step();
        chk("of_fgo_stuck", {7'd0, FGO}, 8'h00);
        chk("of_outr_14", OUTR, 8'h14);
        chk("of_head_10", dev_out_data, 8'h10);
        chk("of_no_overrun", {7'd0, out_overrun}, 8'h00);
        load_OUTR = 1'b1; OUTR_in = 8'h15; out_exp_q.push_back(8'h15);
        step();
        load_OUTR = 1'b0;
        chk("of_overrun", {7'd0, out_overrun}, 8'h01);
        chk("of_outr_15", OUTR, 8'h15);
        dev_out_ready = 1'b1;
        step();
        chk("of_fgo_pop_edge", {7'd0, FGO}, 8'h00);
        step();
        chk("of_fgo_after_pop", {7'd0, FGO}, 8'h01);
        wait_drain("of_drain");
        chk("of_overrun_sticky", {7'd0, out_overrun}, 8'h01);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        chk("sim_overrun_rst", {7'd0, out_overrun}, 8'h00);
        dev_out_ready = 1'b0;
        out_exp_q.push_back(8'h66);
        do_out(8'h66);
        out_exp_q.push_back(8'h77);
        do_out(8'h77);
        chk("sim_fgo_low", {7'd0, FGO}, 8'h00);
        chk("sim_outr_77", OUTR, 8'h77);
        chk("sim_no_overrun", {7'd0, out_overrun}, 8'h00);
        chk("sim_head_66", dev_out_data, 8'h66);
        step();
        chk("sim_fgo_high", {7'd0, FGO}, 8'h01);
        dev_out_ready = 1'b1;
        wait_drain("sim_drain");
        chk("sim_overrun_end", {7'd0, out_overrun}, 8'h00);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        test_reset();
        test_input_path();
        test_in_backpressure();
        test_output_path();
        test_output_full();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/basic_io_unit.md
# basic_io_unit

I/O interface for the basic computer. It sits between the external character devices (keyboard side, printer side) and the CPU's INPR/OUTR/FGI/FGO resources. Each direction has a small FIFO, so device traffic is decoupled from program-driven polling or interrupt service. The block feeds INPR and FGI to the ALU and control unit, and consumes OUTR writes and flag clears issued by the control unit.

## Interface
- IN_DEPTH, 4, input FIFO depth in bytes (power of 2, ≥2)
- OUT_DEPTH, 4, output FIFO depth in bytes (power of 2, ≥2)

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- dev_in_data  in  8  byte from input device
- dev_in_valid  in  1  dev_in_data valid
- dev_in_ready  out  1  input FIFO can accept a byte
- dev_out_data  out  8  byte to output device; 0 when dev_out_valid=0
- dev_out_valid  out  1  output FIFO non-empty
- dev_out_ready  in  1  output device accepts the byte
- INPR  out  8  input register to ALU (from_INPR)
- FGI  out  1  input flag: INPR holds an unread byte
- clr_FGI  in  1  control unit clears FGI (INP executed)
- OUTR_in  in  8  AC[7:0] from CPU
- load_OUTR  in  1  control unit loads OUTR
- clr_FGO  in  1  control unit clears FGO (OUT executed)
- OUTR  out  8  output register contents
- FGO  out  1  output flag: OUTR free for a new byte
- out_overrun  out  1  sticky error: an unsent OUTR byte was overwritten

## Operation
- Reset values: INPR=0, OUTR=0, FGI=0, FGO=1, out_overrun=0, both FIFOs empty, dev_in_ready=1, dev_out_valid=0, dev_out_data=0. An asynchronous reset mid-transfer discards all buffered bytes.
- Input FIFO:
  - dev_in_ready = !in_full.
  - A push occurs on an edge with dev_in_valid & dev_in_ready.
  - No push when full, even if a pop occurs in the same cycle.
- Input refill: on an edge with FGI=0 and the input FIFO non-empty, pop the head into INPR and set FGI=1.
- clr_FGI:
  - When FGI=1, clears FGI on that edge. INPR keeps its value.
  - When FGI=0, no effect.
  - A refill can occur at the earliest one edge after the clear.
- Output side, clearing FGO: clr_FGO clears FGO. load_OUTR loads OUTR from OUTR_in. The control unit asserts both together for OUT.
- Output transfer: on an edge with FGO=0 and the output FIFO not full, push the current (pre-edge) OUTR into the FIFO and set FGO=1.
- Simultaneous transfer and clr_FGO: clr_FGO wins, so FGO=0 after the edge. The old OUTR byte is pushed and the new OUTR_in is latched.
- Output FIFO: dev_out_valid = !out_empty and dev_out_data = head. A pop occurs on dev_out_valid & dev_out_ready. Push and pop in the same cycle are allowed when not full (count unchanged).
- Overrun: load_OUTR on an edge with FGO=0 and no transfer that edge sets out_overrun=1. The overwritten byte is lost. out_overrun clears only on reset.
- FIFO pointers wrap modulo depth. Occupancy is held in a log2(depth)+1-bit counter.

## Timing
- Input latency: a byte pushed at edge k into an empty FIFO with FGI=0 appears in INPR with FGI=1 after edge k+1.
- Back-to-back input: with clr_FGI pulsed each time FGI=1, a new byte is presented every 2 cycles.
- Output latency: clr_FGO+load_OUTR at edge k, with the FIFO not full, gives:
  - FGO=1 and the byte in the FIFO after edge k+1;
  - dev_out_valid=1 after edge k+1.
- Output FIFO full: FGO stays 0 until a pop frees a slot. The transfer happens on the edge after the pop edge.
- dev_in_ready, dev_out_valid, FGI and FGO are all registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle → immediately INPR=0, FGI=0, FGO=1, OUTR=0, dev_in_ready=1, dev_out_valid=0, out_overrun=0.
- Input path:
  - push 0xAB, then 0xCD with FGI polled.
  - → INPR=0xAB, FGI=1 one edge after the push.
  - clr_FGI → FGI=0, then INPR=0xCD, FGI=1 one edge later.
- Input backpressure:
  - hold dev_in_valid with bytes 0x01..0x06 and never clr_FGI.
  - → INPR=0x01; FIFO holds 0x02..0x05; dev_in_ready=0.
  - 0x06 is not accepted until clr_FGI.
- Output path:
  - clr_FGO+load_OUTR with OUTR_in=0x5A, dev_out_ready=1.
  - → FGO=0, OUTR=0x5A, then FGO=1, then dev_out_valid=1, dev_out_data=0x5A for one cycle.
- Output full and overrun:
  - dev_out_ready=0; write 0x10..0x14 via OUT.
  - → FIFO holds 0x10..0x13, OUTR=0x14, FGO=0.
  - load_OUTR with 0x15 → out_overrun=1 and 0x14 is lost.
  - Then release dev_out_ready → device receives 0x10..0x13, then 0x15.
- Simultaneous events:
  - clr_FGO+load_OUTR(0x77) on the same edge a pending 0x66 transfers.
  - → 0x66 is pushed, OUTR=0x77, FGO=0, no overrun.
  - 0x77 is pushed one edge later.
